reg_wb_scheduler: RTL and testbench
===================================

# reg_wb_scheduler

Writeback scheduler and scoreboard for the register file write port. Arbitrates round-robin among `num_src` writeback sources (ALU, load unit, multiplier) onto the single write port (`wenable`/`rd`/`rd_in`). Tracks a busy bit per register, so the issue stage stalls any instruction whose sources or destination have a write still pending. Sits between the execute units and the register file, beside the decode/issue logic.

## Interface
- `width`, 32, data width; matches the register file.
- `total_reg`, 20, number of architectural registers.
- `address_reg`, `$clog2(total_reg)`, register address bits.
- `num_src`, 3, number of writeback sources; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  `num_src`  source i has a result to write.
- `src_rd`  in  `num_src` x `address_reg`  destination register of source i.
- `src_data`  in  `num_src` x `width`  result of source i.
- `src_ready`  out  `num_src`  grant; source i's result is consumed at this edge.
- `wenable`  out  1  register file write enable (registered).
- `rd`  out  `address_reg`  register file write address (registered).
- `rd_in`  out  `width`  register file write data (registered).
- `issue_valid`  in  1  the issue stage presents an instruction.
- `issue_rs1`, `issue_rs2`  in  `address_reg`  source registers of the instruction.
- `issue_rd`  in  `address_reg`  destination register of the instruction.
- `issue_wr`  in  1  the instruction writes `issue_rd`.
- `issue_stall`  out  1  the instruction must not issue this cycle (combinational).

## Operation
- **Arbitration.** `src_ready` is one-hot or zero.
  - At most one grant per cycle. The grant is always given when any `src_valid` is high, because the write port retires one write per cycle.
  - `src_ready[i]` is only ever high when `src_valid[i]` is high.
  - Priority is round-robin. The search starts at `last+1` modulo `num_src`, where `last` is the most recently granted index.
  - `last` updates only on a grant. After reset `last = num_src-1`, so source 0 has first priority.
- **Source handshake.** A source holds valid, rd and data stable until it is granted. The transfer occurs on any edge where `src_valid[i] & src_ready[i]`.
- **Write port.** On a granted edge, the output register loads `rd <= src_rd[g]`, `rd_in <= src_data[g]`, `wenable <= (src_rd[g] != 0)`.
  - A grant with `rd = 0` is consumed and dropped (x0 is never written).
  - With no grant, `wenable <= 0`, and `rd`/`rd_in` hold their values.
- **Scoreboard.** `busy[total_reg-1:0]`; `busy[0]` is always 0.
  - Set: `busy[issue_rd] <= 1` on an edge where `issue_valid & issue_wr & ~issue_stall & issue_rd != 0`.
  - Clear: `busy[rd] <= 0` on an edge where `wenable` is high. This is the same edge on which the register file commits the write.
  - Set and clear of the same register on the same edge: the set wins. This can only occur for an outstanding write to a different instance, which is prevented by the stall below. It is still required for robustness.
- **Stall.**
  - `issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | (issue_wr & busy[issue_rd]))`.
  - The stall uses registered `busy` only. There is no bypass from the write currently in flight.
  - The stall covers RAW hazards, and WAW hazards via the `issue_rd` check.
- **Out-of-range addresses.** Any address `>= total_reg` reads busy as 0 and is never set.

## Timing
- **Reset.** All outputs are reset asynchronously while `rst_n` is low: `wenable=0`, `rd=0`, `rd_in=0`, `busy=0`, `last=num_src-1`.
  - `src_ready` and `issue_stall` are combinational and evaluate to 0 while all inputs are low.
  - A write accepted but not yet committed when reset asserts is lost.
- **Latency.** A source granted at edge N drives `wenable`/`rd`/`rd_in` during cycle N..N+1. The register file writes at edge N+1, and `busy` clears at edge N+1. A dependent instruction can issue in the cycle after edge N+1, reading the new value.
- **Throughput.** One write per cycle, sustained. With k sources continuously valid, each is granted once every k cycles.
- **Issue latency.** An instruction that issues at edge M sets `busy` at edge M. A dependent instruction at cycle M+1 stalls.

## Structure
- **Package `reg_ctrl_pkg`:** default `width`/`total_reg`/`num_src` constants, and the `REG_ZERO` address constant.
- **Sub-module `rr_arbiter`:** parameterised by `num_src`. Inputs are `req` and `clk`/`rst_n`. Outputs are a one-hot `gnt` and the `last` pointer register. The pointer advances on any nonzero grant.
- **Top level:** output register, scoreboard and stall logic.

## Test plan
- **Reset:** assert `rst_n=0` mid-traffic -> `wenable=0`, `rd=0`, `rd_in=0`, all `busy=0` immediately. The first grant after release goes to src0 when all sources are valid.
- **Round-robin fairness:** `num_src=3`, all `src_valid` held high with rd=1,2,3 -> grants 0,1,2,0,1,2. `wenable` is high every cycle, with `rd` sequence 1,2,3,1,... one cycle behind the grants.
- **x0 drop:** src1 valid with rd=0, data=32'hDEAD -> `src_ready[1]` pulses and `wenable` stays 0. No `busy` bit changes.
- **RAW stall:** issue rd=5 at edge M, then issue rs1=5 -> `issue_stall=1` until src0 writes rd=5. The stall falls the cycle after that write's `wenable` edge.
- **WAW and simultaneity:** `busy[7]` is set, and an issue with rd=7 arrives -> stall. On the commit edge of rd=7, the issue is still stalled and is accepted the next cycle. `busy[7]` ends at 1.
- **Idle hold:** no sources valid for 4 cycles after writing rd=3, data=32'h1234 -> `wenable=0`, while `rd=3` and `rd_in=32'h1234` hold.

Source files
------------

// File: rtl/reg_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctrl_pkg
// Description : Shared constants and helpers for the writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_ctrl_pkg;

  localparam int c_width     = 32;
  localparam int c_total_reg = 20;
  localparam int c_num_src   = 3;
  localparam int c_addr_w    = $clog2(c_total_reg);

  // Register x0 is hardwired to zero and never tracked or written.
  localparam int REG_ZERO    = 0;

  // Width of a pointer into n entries, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_scheduler_if
// Description : Writeback source, register-file write port and issue signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_scheduler_if
  import reg_ctrl_pkg::*;
#(
  parameter int WIDTH       = c_width,
  parameter int ADDRESS_REG = c_addr_w,
  parameter int NUM_SRC     = c_num_src
);

  logic [NUM_SRC-1:0]                  src_valid;
  logic [NUM_SRC-1:0][ADDRESS_REG-1:0] src_rd;
  logic [NUM_SRC-1:0][WIDTH-1:0]       src_data;
  logic [NUM_SRC-1:0]                  src_ready;

  logic                                wenable;
  logic [ADDRESS_REG-1:0]              rd;
  logic [WIDTH-1:0]                    rd_in;

  logic                                issue_valid;
  logic [ADDRESS_REG-1:0]              issue_rs1;
  logic [ADDRESS_REG-1:0]              issue_rs2;
  logic [ADDRESS_REG-1:0]              issue_rd;
  logic                                issue_wr;
  logic                                issue_stall;

  // Drives sources and issue requests; observes grants, write port and stall.
  modport master (
    output src_valid, src_rd, src_data,
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    input  src_ready, wenable, rd, rd_in, issue_stall
  );

  modport slave (
    input  src_valid, src_rd, src_data,
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    output src_ready, wenable, rd, rd_in, issue_stall
  );

endinterface
`default_nettype wire

// File: rtl/reg_wb_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, search starts one past the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_SRC = c_num_src
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               req,
  output logic [NUM_SRC-1:0]               gnt,
  output logic [ptr_width(NUM_SRC)-1:0]    last
);

  localparam int c_ptr_w = ptr_width(NUM_SRC);

  logic [c_ptr_w-1:0] r_last;
  logic [NUM_SRC-1:0] w_gnt;
  logic [c_ptr_w-1:0] w_idx;
  logic               w_found;
  int                 w_cand;

  // r_last < NUM_SRC and k <= NUM_SRC, so a single wrap subtraction suffices.
  always_comb begin
    w_gnt   = '0;
    w_idx   = r_last;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = int'(r_last) + k;
      if (w_cand >= NUM_SRC) begin
        w_cand = w_cand - NUM_SRC;
      end
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        w_gnt[w_cand] = 1'b1;
        w_idx         = c_ptr_w'(w_cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_ptr_w'(NUM_SRC - 1);
    end else if (w_found) begin
      r_last <= w_idx;
    end
  end

  assign gnt  = w_gnt;
  assign last = r_last;

endmodule
`default_nettype wire

// File: rtl/reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_scheduler
// Description : Writeback arbitration onto the register-file port plus busy
//               scoreboard driving the issue-stage stall.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_scheduler
  import reg_ctrl_pkg::*;
#(
  parameter int WIDTH       = c_width,
  parameter int TOTAL_REG   = c_total_reg,
  parameter int ADDRESS_REG = $clog2(TOTAL_REG),
  parameter int NUM_SRC     = c_num_src
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_wb_scheduler_if.slave  bus
);

  localparam int c_ptr_w = ptr_width(NUM_SRC);
  localparam int c_ext   = 1 << ADDRESS_REG;

  logic [NUM_SRC-1:0]     w_gnt;
  logic [c_ptr_w-1:0]     w_unused_last;
  logic                   w_gnt_any;
  logic [ADDRESS_REG-1:0] w_sel_rd;
  logic [WIDTH-1:0]       w_sel_data;

  logic                   r_wenable;
  logic [ADDRESS_REG-1:0] r_rd;
  logic [WIDTH-1:0]       r_rd_in;

  logic [TOTAL_REG-1:0]   r_busy;
  logic [TOTAL_REG-1:0]   w_busy_nxt;
  logic [c_ext-1:0]       w_busy_ext;
  logic                   w_stall;
  logic                   w_set;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.src_valid),
    .gnt   (w_gnt),
    .last  (w_unused_last)
  );

  // Grant is one-hot, so an OR-mux picks the winning source.
  always_comb begin
    w_gnt_any  = |w_gnt;
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) begin
        w_sel_rd   = w_sel_rd | bus.src_rd[i];
        w_sel_data = w_sel_data | bus.src_data[i];
      end
    end
  end

  // Addresses beyond TOTAL_REG land in the zero padding and read not-busy.
  always_comb begin
    w_busy_ext                = '0;
    w_busy_ext[TOTAL_REG-1:0] = r_busy;
  end

  assign w_stall = bus.issue_valid &
                   (w_busy_ext[bus.issue_rs1] | w_busy_ext[bus.issue_rs2] |
                    (bus.issue_wr & w_busy_ext[bus.issue_rd]));

  assign w_set = bus.issue_valid & bus.issue_wr & ~w_stall;

  // Clear applied before set so a same-edge set on one register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < TOTAL_REG; i++) begin
      if (r_wenable && (r_rd == ADDRESS_REG'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
      if (w_set && (bus.issue_rd == ADDRESS_REG'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wenable <= 1'b0;
      r_rd      <= '0;
      r_rd_in   <= '0;
      r_busy    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_gnt_any) begin
        r_wenable <= (w_sel_rd != ADDRESS_REG'(REG_ZERO));
        r_rd      <= w_sel_rd;
        r_rd_in   <= w_sel_data;
      end else begin
        r_wenable <= 1'b0;
      end
    end
  end

  assign bus.src_ready   = w_gnt;
  assign bus.wenable     = r_wenable;
  assign bus.rd          = r_rd;
  assign bus.rd_in       = r_rd_in;
  assign bus.issue_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_scheduler
// Description : Directed bench with a reference model for reg_wb_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_scheduler;

  localparam int W  = 32;
  localparam int TR = 20;
  localparam int AW = 5;
  localparam int NS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_scheduler_if #(.WIDTH(W), .ADDRESS_REG(AW), .NUM_SRC(NS)) bus ();

  reg_wb_scheduler #(
    .WIDTH(W), .TOTAL_REG(TR), .ADDRESS_REG(AW), .NUM_SRC(NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scoreboard array, last-grant index, pending write.
  bit          m_busy [32];
  int          m_last;
  bit          m_wen;
  int          m_rd;
  logic [31:0] m_data;

  function automatic int pick(input logic [NS-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NS; k++) begin
      c = (last + k) % NS;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit mbusy(input int a);
    return (a < TR) ? m_busy[a] : 1'b0;
  endfunction

  function automatic bit mstall();
    return bus.issue_valid && (mbusy(int'(bus.issue_rs1)) || mbusy(int'(bus.issue_rs2)) ||
                               (bus.issue_wr && mbusy(int'(bus.issue_rd))));
  endfunction

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last = NS - 1;
    m_wen  = 1'b0;
    m_rd   = 0;
    m_data = '0;
  endtask

  task automatic m_step();
    int g;
    bit st;
    bit set;
    g   = pick(bus.src_valid, m_last);
    st  = mstall();
    set = bus.issue_valid && bus.issue_wr && !st &&
          (bus.issue_rd != 0) && (int'(bus.issue_rd) < TR);
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (set)   m_busy[bus.issue_rd] = 1'b1;
    if (g >= 0) begin
      m_last = g;
      m_wen  = (bus.src_rd[g] != 0);
      m_rd   = int'(bus.src_rd[g]);
      m_data = bus.src_data[g];
    end else begin
      m_wen = 1'b0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int g;
        logic [NS-1:0] eg;
        g  = pick(bus.src_valid, m_last);
        eg = (g >= 0) ? (NS'(1) << g) : '0;
        chk("src_ready", bus.src_ready, eg);
        chk("wenable", bus.wenable, m_wen);
        chk("rd", bus.rd, m_rd);
        chk("rd_in", bus.rd_in, m_data);
        chk("issue_stall", bus.issue_stall, mstall());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.src_valid   = '0;
    bus.src_rd      = '0;
    bus.src_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_wr    = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] r, input logic [W-1:0] d);
    bus.src_valid[i] = v;
    bus.src_rd[i]    = r;
    bus.src_data[i]  = d;
  endtask

  task automatic issue(input logic v, input logic wr, input logic [AW-1:0] rdx,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.issue_valid = v;
    bus.issue_wr    = wr;
    bus.issue_rd    = rdx;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
  endtask

  logic [NS-1:0] exp_g  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  int            exp_rd [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk("rst_wenable", bus.wenable, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_rd_in", bus.rd_in, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_stall", bus.issue_stall, 0);
    step(); step();
    rst_n = 1'b1;

    // Round-robin with all sources valid
    set_src(0, 1'b1, 5'd1, 32'hA0);
    set_src(1, 1'b1, 5'd2, 32'hA1);
    set_src(2, 1'b1, 5'd3, 32'hA2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_gnt", bus.src_ready, exp_g[i]);
      if (i > 0) begin
        chk("rr_wen", bus.wenable, 1);
        chk("rr_rd", bus.rd, exp_rd[i-1]);
      end
    end

    // Idle hold after writing rd=3
    step();
    idle_inputs();
    set_src(0, 1'b1, 5'd3, 32'h1234);
    @(negedge clk);
    chk("hold_gnt", bus.src_ready, 3'b001);
    step();
    bus.src_valid = '0;
    @(negedge clk);
    chk("hold_wen1", bus.wenable, 1);
    chk("hold_rd1", bus.rd, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_wen0", bus.wenable, 0);
      chk("hold_rd", bus.rd, 3);
      chk("hold_rd_in", bus.rd_in, 32'h1234);
    end

    // x0 write is consumed and dropped
    step();
    set_src(1, 1'b1, 5'd0, 32'hDEAD);
    @(negedge clk);
    chk("x0_gnt", bus.src_ready, 3'b010);
    step();
    bus.src_valid = '0;
    @(negedge clk);
    chk("x0_wen", bus.wenable, 0);

    // RAW stall on r5 until its write commits
    step();
    issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    @(negedge clk);
    chk("raw_issue", bus.issue_stall, 0);
    step();
    issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
    @(negedge clk);
    chk("raw_stall", bus.issue_stall, 1);
    step();
    @(negedge clk);
    chk("raw_stall_hold", bus.issue_stall, 1);
    step();
    set_src(0, 1'b1, 5'd5, 32'h55);
    @(negedge clk);
    chk("raw_stall_pre", bus.issue_stall, 1);
    step();
    bus.src_valid = '0;
    @(negedge clk);
    chk("raw_commit_wen", bus.wenable, 1);
    chk("raw_commit_rd", bus.rd, 5);
    chk("raw_commit_stall", bus.issue_stall, 1);
    step();
    @(negedge clk);
    chk("raw_release", bus.issue_stall, 0);

    // WAW on r7, stalled through the commit edge
    step();
    issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    @(negedge clk);
    chk("waw_first", bus.issue_stall, 0);
    step();
    @(negedge clk);
    chk("waw_stall", bus.issue_stall, 1);
    step();
    set_src(2, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    chk("waw_stall_gnt", bus.issue_stall, 1);
    step();
    bus.src_valid = '0;
    @(negedge clk);
    chk("waw_commit_wen", bus.wenable, 1);
    chk("waw_commit_stall", bus.issue_stall, 1);
    step();
    @(negedge clk);
    chk("waw_accept", bus.issue_stall, 0);
    step();
    issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
    @(negedge clk);
    chk("waw_busy7", bus.issue_stall, 1);

    // Set and clear of r9 on one edge: set wins
    step();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_src(0, 1'b1, 5'd9, 32'h99);
    step();
    bus.src_valid = '0;
    issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    @(negedge clk);
    chk("sw_wen", bus.wenable, 1);
    chk("sw_rd", bus.rd, 9);
    chk("sw_nostall", bus.issue_stall, 0);
    step();
    issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    chk("sw_busy9", bus.issue_stall, 1);

    // Out-of-range register is never busy
    step();
    issue(1'b1, 1'b1, 5'd25, 5'd0, 5'd0);
    @(negedge clk);
    chk("oor_issue", bus.issue_stall, 0);
    step();
    issue(1'b1, 1'b0, 5'd0, 5'd25, 5'd25);
    @(negedge clk);
    chk("oor_read", bus.issue_stall, 0);

    // Reset mid-traffic
    step();
    issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd7);
    set_src(0, 1'b1, 5'd1, 32'hB0);
    set_src(1, 1'b1, 5'd2, 32'hB1);
    set_src(2, 1'b1, 5'd3, 32'hB2);
    @(negedge clk);
    chk("pre_rst_stall", bus.issue_stall, 1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", bus.wenable, 0);
    chk("mrst_rd", bus.rd, 0);
    chk("mrst_rd_in", bus.rd_in, 0);
    chk("mrst_stall", bus.issue_stall, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_first_gnt", bus.src_ready, 3'b001);
    step();
    @(negedge clk);
    chk("mrst_first_wen", bus.wenable, 1);
    chk("mrst_first_rd", bus.rd, 1);

    step();
    idle_inputs();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
